// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative multiply and shifts.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  localparam logic [2:0] OP_FWD = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SW-1:0]    shamt_in_c;
  logic [SW-1:0]    shamt_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] step_c;
  logic [WIDTH-1:0] fin_res_c;
  logic             fin_carry_c;
  logic             fin_ovf_c;

  assign shamt_in_c = DATA2[SW-1:0];
  assign shamt_c    = b_q[SW-1:0];
  assign sum_c      = {1'b0, a_q} + {1'b0, b_q};
  assign diff_c     = {1'b0, a_q} - {1'b0, b_q};

  // One iteration of the multi-cycle ops (shift-add multiply, single-bit shifts).
  always_comb begin
    step_c = acc_q;
    case (op_q)
      OP_MUL:  step_c = acc_q + (b_q[0] ? a_q : '0);
      OP_SLL:  if (shamt_c != '0) step_c = acc_q << 1;
      OP_SRA:  if (shamt_c != '0) step_c = $unsigned($signed(acc_q) >>> 1);
      default: step_c = acc_q;
    endcase
  end

  // Result and flags presented at the completing edge.
  always_comb begin
    fin_res_c   = '0;
    fin_carry_c = 1'b0;
    fin_ovf_c   = 1'b0;
    case (op_q)
      OP_FWD: fin_res_c = b_q;
      OP_ADD: begin
        fin_res_c   = sum_c[WIDTH-1:0];
        fin_carry_c = sum_c[WIDTH];
        fin_ovf_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: fin_res_c = a_q & b_q;
      OP_OR:  fin_res_c = a_q | b_q;
      OP_SUB: begin
        fin_res_c   = diff_c[WIDTH-1:0];
        fin_carry_c = ~diff_c[WIDTH];
        fin_ovf_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: fin_res_c = step_c;
    endcase
  end

  // Next-state and next-output logic for the IDLE/EXEC controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = DATA1;
          b_d     = DATA2;
          op_d    = SELECT;
          acc_d   = (SELECT == OP_MUL) ? '0 : DATA1;
          state_d = S_EXEC;
          busy_d  = 1'b1;
          case (SELECT)
            OP_MUL:         cnt_d = CW'(WIDTH);
            OP_SLL, OP_SRA: cnt_d = (shamt_in_c == '0) ? CW'(1) : {1'b0, shamt_in_c};
            default:        cnt_d = CW'(1);
          endcase
        end
      end
      S_EXEC: begin
        acc_d = step_c;
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end
        if (cnt_q == CW'(1)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = fin_res_c;
          zero_d   = (fin_res_c == '0);
          carry_d  = fin_carry_c;
          ovf_d    = fin_ovf_c;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign RESULT   = result_q;
  assign ZERO     = zero_q;
  assign CARRY    = carry_q;
  assign OVERFLOW = ovf_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
